// File: rtl/mod_count_sampler_if.sv
// Bundle of the sampler's data-side signals: the raw ripple count and clear
// request going in, the filtered count, step/wrap pulses, step total and
// error flag coming out.
interface mod_count_sampler_if #(
  parameter int N       = 5,
  parameter int TOTAL_W = 16
);
  localparam int W = $clog2(N);

  logic [W-1:0]       count_i;
  logic               clear_i;
  logic [W-1:0]       stable_count_o;
  logic               step_o;
  logic               wrap_o;
  logic [TOTAL_W-1:0] total_o;
  logic               err_o;

  modport master (
    output count_i, clear_i,
    input  stable_count_o, step_o, wrap_o, total_o, err_o
  );

  modport slave (
    input  count_i, clear_i,
    output stable_count_o, step_o, wrap_o, total_o, err_o
  );
endinterface

// File: rtl/mod_count_sampler.sv
// Samples the output of an asynchronous mod-N ripple counter into the clk_i
// domain. A two-flop synchronizer plus a history register form a glitch
// filter: only a value seen unchanged on two consecutive edges is acted on.
// Accepted +1 advances pulse step_o (and wrap_o on N-1 -> 0) and bump a
// running total; skipped or out-of-range counts raise a sticky error.
module mod_count_sampler #(
  parameter int N       = 5,
  parameter int TOTAL_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  mod_count_sampler_if.slave bus
);
  localparam int W = $clog2(N);
  localparam logic [W-1:0] LAST_CNT = W'(N - 1);
  localparam logic [W:0]   MODULUS  = (W + 1)'(N);

  // Successor of a legal count in the mod-N sequence.
  function automatic logic [W-1:0] mod_succ(input logic [W-1:0] c);
    return (c == LAST_CNT) ? '0 : c + W'(1);
  endfunction

  logic [W-1:0]       s1_q, s1_d;
  logic [W-1:0]       s2_q, s2_d;
  logic [W-1:0]       s3_q, s3_d;
  logic [W-1:0]       stable_q, stable_d;
  logic               step_q, step_d;
  logic               wrap_q, wrap_d;
  logic [TOTAL_W-1:0] total_q, total_d;
  logic               err_q, err_d;

  logic               qualified;
  logic               in_range;

  // Synchronizer chain and history tap; s1 -> s2 is a straight wire.
  always_comb begin
    s1_d = bus.count_i;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  // Synchronizer / history registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign qualified = (s2_q == s3_q);
  assign in_range  = ({1'b0, s2_q} < MODULUS);

  // Classify a qualified sample against the current stable count; clear
  // overrides the total and error results but not the count or pulses.
  always_comb begin
    stable_d = stable_q;
    step_d   = 1'b0;
    wrap_d   = 1'b0;
    total_d  = total_q;
    err_d    = err_q;

    if (qualified) begin
      if (!in_range) begin
        err_d = 1'b1;
      end else if (s2_q == stable_q) begin
        stable_d = stable_q;
      end else if (s2_q == mod_succ(stable_q)) begin
        stable_d = s2_q;
        step_d   = 1'b1;
        wrap_d   = (stable_q == LAST_CNT);
        total_d  = total_q + TOTAL_W'(1);
      end else begin
        stable_d = s2_q;
        err_d    = 1'b1;
      end
    end

    if (bus.clear_i) begin
      total_d = '0;
      err_d   = 1'b0;
    end
  end

  // Output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stable_q <= '0;
      step_q   <= 1'b0;
      wrap_q   <= 1'b0;
      total_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      stable_q <= stable_d;
      step_q   <= step_d;
      wrap_q   <= wrap_d;
      total_q  <= total_d;
      err_q    <= err_d;
    end
  end

  assign bus.stable_count_o = stable_q;
  assign bus.step_o         = step_q;
  assign bus.wrap_o         = wrap_q;
  assign bus.total_o        = total_q;
  assign bus.err_o          = err_q;
endmodule

// File: tb/tb_mod_count_sampler.sv
// Bench for mod_count_sampler: table of held counts with expected end
// states, hand-written latency / clear / async-reset sequences, and a
// randomized run, all tracked cycle by cycle by a reference model.
module tb_mod_count_sampler;
  localparam int N  = 5;
  localparam int TW = 16;
  localparam int W  = $clog2(N);

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  mod_count_sampler_if #(.N(N), .TOTAL_W(TW)) bus_if();

  mod_count_sampler #(.N(N), .TOTAL_W(TW)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus_if)
  );

  int checks = 0;
  int errors = 0;

  int drv_cnt = 0;
  bit drv_clr = 1'b0;

  // Reference model state
  int m_stable, m_total;
  bit m_step, m_wrap, m_err;
  int samp[$];   // count_i values sampled on recent edges, newest last

  int step_seen, wrap_seen;

  typedef struct {
    int cnt;
    bit clr;
    int hold;
    int e_stable;
    int e_total;
    bit e_err;
    int e_steps;
    int e_wraps;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(int c, bit cl);
    drv_cnt = c;
    drv_clr = cl;
    bus_if.count_i = W'(c);
    bus_if.clear_i = cl;
  endtask

  task automatic model_reset();
    m_stable = 0; m_total = 0; m_step = 0; m_wrap = 0; m_err = 0;
    samp = {0, 0, 0};
  endtask

  // A count is acted on at an edge when it was sampled identically on the
  // edges two and three back; it is then judged against the stable count.
  task automatic model_edge();
    int v;
    m_step = 0;
    m_wrap = 0;
    if (samp[0] == samp[1]) begin
      v = samp[1];
      if (v >= N) begin
        m_err = 1;
      end else if (v != m_stable) begin
        if (v == (m_stable + 1) % N) begin
          m_step = 1;
          m_wrap = (v == 0);
          m_total = (m_total + 1) % (1 << TW);
        end else begin
          m_err = 1;
        end
        m_stable = v;
      end
    end
    if (drv_clr) begin
      m_total = 0;
      m_err = 0;
    end
    samp.push_back(drv_cnt);
    void'(samp.pop_front());
  endtask

  task automatic check_all(string tag);
    chk({tag, "_stable"}, int'(bus_if.stable_count_o), m_stable);
    chk({tag, "_step"},   int'(bus_if.step_o),         int'(m_step));
    chk({tag, "_wrap"},   int'(bus_if.wrap_o),         int'(m_wrap));
    chk({tag, "_total"},  int'(bus_if.total_o),        m_total);
    chk({tag, "_err"},    int'(bus_if.err_o),          int'(m_err));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all("cyc");
    if (bus_if.step_o) step_seen++;
    if (bus_if.wrap_o) wrap_seen++;
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_stable"}, int'(bus_if.stable_count_o), 0);
    chk({tag, "_step"},   int'(bus_if.step_o),         0);
    chk({tag, "_wrap"},   int'(bus_if.wrap_o),         0);
    chk({tag, "_total"},  int'(bus_if.total_o),        0);
    chk({tag, "_err"},    int'(bus_if.err_o),          0);
  endtask

  // Reset asserted between clock edges, checked before any edge arrives,
  // held across one rising edge and released on a falling edge.
  task automatic async_reset(string tag);
    #2 rst_n = 1'b0;
    #1 check_zero(tag);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int cur, nxt, hold;

    set_in(0, 0);
    #1 rst_n = 1'b0;
    model_reset();
    #1 check_zero("reset");
    @(negedge clk);
    @(negedge clk);
    check_zero("reset_held");
    rst_n = 1'b1;
    repeat (3) tick();

    // ---------------- table-driven sequence ----------------
    tbl[0]  = '{1, 0, 10, 1, 1, 0, 1, 0};
    tbl[1]  = '{2, 0,  6, 2, 2, 0, 1, 0};
    tbl[2]  = '{0, 0,  1, 2, 2, 0, 0, 0};  // one-cycle glitch
    tbl[3]  = '{3, 0,  6, 3, 3, 0, 1, 0};
    tbl[4]  = '{4, 0,  6, 4, 4, 0, 1, 0};
    tbl[5]  = '{0, 0,  6, 0, 5, 0, 1, 1};
    tbl[6]  = '{1, 0,  6, 1, 6, 0, 1, 0};
    tbl[7]  = '{3, 0,  6, 3, 6, 1, 0, 0};  // skipped step
    tbl[8]  = '{3, 1,  1, 3, 0, 0, 0, 0};  // clear
    tbl[9]  = '{6, 0,  6, 3, 0, 1, 0, 0};  // out of range
    tbl[10] = '{4, 0,  6, 4, 1, 1, 1, 0};
    tbl[11] = '{0, 0,  6, 0, 2, 1, 1, 1};

    for (int i = 0; i < 12; i++) begin
      set_in(tbl[i].cnt, tbl[i].clr);
      step_seen = 0;
      wrap_seen = 0;
      repeat (tbl[i].hold) tick();
      chk($sformatf("tbl%0d_stable", i), int'(bus_if.stable_count_o), tbl[i].e_stable);
      chk($sformatf("tbl%0d_total", i),  int'(bus_if.total_o),        tbl[i].e_total);
      chk($sformatf("tbl%0d_err", i),    int'(bus_if.err_o),          int'(tbl[i].e_err));
      chk($sformatf("tbl%0d_steps", i),  step_seen,                   tbl[i].e_steps);
      chk($sformatf("tbl%0d_wraps", i),  wrap_seen,                   tbl[i].e_wraps);
    end
    set_in(0, 0);

    // ------ clear on the step edge, then reset mid-filter ------
    async_reset("rst_a");
    repeat (3) tick();
    for (int i = 0; i < 7; i++) begin
      set_in((i + 1) % N, 0);
      repeat (4) tick();
    end
    chk("pre_clear_total", int'(bus_if.total_o), 7);
    chk("pre_clear_stable", int'(bus_if.stable_count_o), 2);
    set_in(3, 0);
    repeat (3) tick();
    chk("latency_early_stable", int'(bus_if.stable_count_o), 2);
    chk("latency_early_step", int'(bus_if.step_o), 0);
    set_in(3, 1);
    tick();
    chk("clr_step_step", int'(bus_if.step_o), 1);
    chk("clr_step_total", int'(bus_if.total_o), 0);
    chk("clr_step_stable", int'(bus_if.stable_count_o), 3);
    set_in(3, 0);
    tick();
    chk("clr_step_after", int'(bus_if.step_o), 0);
    set_in(4, 0);
    repeat (2) tick();
    async_reset("rst_mid");
    step_seen = 0;
    repeat (6) tick();
    chk("post_rst_steps", step_seen, 0);
    chk("post_rst_stable", int'(bus_if.stable_count_o), 4);
    chk("post_rst_err", int'(bus_if.err_o), 1);

    // ---------------- randomized run ----------------
    async_reset("rst_rand");
    set_in(0, 0);
    cur = 0;
    for (int it = 0; it < 200; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: nxt = (cur + 1) % N;
        6, 7:             nxt = int'($urandom_range(0, (1 << W) - 1));
        default:          nxt = cur;
      endcase
      hold = int'($urandom_range(1, 5));
      for (int h = 0; h < hold; h++) begin
        set_in(nxt, ($urandom_range(0, 19) == 0));
        tick();
      end
      cur = nxt;
      if (it == 100) async_reset("rst_rand_mid");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
